// File: rtl/buf_updater_mc_if.sv
// Wishbone classic bus between the buffer updater (master) and the shared memory (slave).
interface buf_updater_mc_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wbm_address;
  logic [DATA_WIDTH-1:0] wbm_writedata;
  logic [DATA_WIDTH-1:0] wbm_readdata;
  logic                  wbm_strobe;
  logic                  wbm_cycle;
  logic                  wbm_write;
  logic                  wbm_ack;

  modport master (
    output wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    input  wbm_readdata, wbm_ack
  );
  modport slave (
    input  wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    output wbm_readdata, wbm_ack
  );
endinterface

// File: rtl/buf_updater_mc.sv
// Round-robin multi-channel buffer copy/fill engine acting as a Wishbone classic master.
module buf_updater_mc #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_CH      = 4,
  parameter int                    BUF_WORDS   = 64,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE    = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] DST_BASE    = 16'h8000,
  parameter int                    ACK_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  buf_updater_mc_if.master             wb,
  input  logic [NUM_CH*DATA_WIDTH-1:0] buf_id,
  input  logic [NUM_CH-1:0]            update_buf,
  input  logic [NUM_CH-1:0]            fill_mode,
  input  logic [DATA_WIDTH-1:0]        fill_data,
  output logic [NUM_CH-1:0]            buf_updated,
  output logic [NUM_CH-1:0]            buf_error
);
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WORD_BITS = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d, rr_q, rr_d;
  logic                    fill_q, fill_d;
  logic [DATA_WIDTH-1:0]   buf_id_q, buf_id_d;
  logic [WORD_BITS-1:0]    word_q, word_d;
  logic [7:0]              to_q, to_d;
  logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [NUM_CH-1:0]       updated_q, updated_d, error_q, error_d;

  logic [NUM_CH-1:0]       elig;
  logic                    gnt_valid;
  logic [CH_W-1:0]         gnt_ch;
  logic [DATA_WIDTH-1:0]   gnt_id;
  int                      idx;

  function automatic logic [ADDR_WIDTH-1:0] src_addr(input logic [DATA_WIDTH-1:0] id,
                                                     input logic [WORD_BITS-1:0] w);
    return SRC_BASE + (ADDR_WIDTH'(id) << WORD_BITS) + ADDR_WIDTH'(w);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] dst_addr(input logic [CH_W-1:0] c,
                                                     input logic [WORD_BITS-1:0] w);
    return DST_BASE + (ADDR_WIDTH'(c) << WORD_BITS) + ADDR_WIDTH'(w);
  endfunction

  // In DONE the finishing channel's buf_updated is not yet visible, so mask it explicitly.
  always_comb begin
    elig = update_buf & ~updated_q;
    if (state_q == S_DONE) elig[ch_q] = 1'b0;
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_valid && elig[idx]) begin
        gnt_valid = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
    gnt_id = buf_id[gnt_ch*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rr_d      = rr_q;
    fill_d    = fill_q;
    buf_id_d  = buf_id_q;
    word_d    = word_q;
    to_d      = to_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    updated_d = updated_q & update_buf;
    error_d   = error_q & update_buf;

    case (state_q)
      S_RD, S_WR: begin
        if (!stb_q) begin
          // Launch the next access after the one-cycle bus gap.
          cyc_d = 1'b1;
          stb_d = 1'b1;
          to_d  = '0;
          if (state_q == S_RD) begin
            we_d  = 1'b0;
            adr_d = src_addr(buf_id_q, word_q);
          end else begin
            we_d  = 1'b1;
            adr_d = dst_addr(ch_q, word_q);
          end
        end else if (wb.wbm_ack) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (state_q == S_RD) begin
            dat_d   = wb.wbm_readdata;
            state_d = S_WR;
          end else begin
            word_d = word_q + WORD_BITS'(1);
            if (word_q == WORD_BITS'(BUF_WORDS-1)) state_d = S_DONE;
            else                                   state_d = fill_q ? S_WR : S_RD;
          end
        end else if (to_q == 8'(ACK_TIMEOUT-1)) begin
          cyc_d           = 1'b0;
          stb_d           = 1'b0;
          we_d            = 1'b0;
          updated_d[ch_q] = 1'b1;
          error_d[ch_q]   = 1'b1;
          state_d         = S_IDLE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      S_DONE: begin
        updated_d[ch_q] = 1'b1;
        error_d[ch_q]   = 1'b0;
        state_d         = S_IDLE;
      end
      default: ;
    endcase

    // The first access is launched on the grant edge so back-to-back transfers keep a single idle cycle.
    if ((state_q == S_IDLE || state_q == S_DONE) && gnt_valid) begin
      ch_d     = gnt_ch;
      rr_d     = (gnt_ch == CH_W'(NUM_CH-1)) ? '0 : gnt_ch + CH_W'(1);
      fill_d   = fill_mode[gnt_ch];
      buf_id_d = gnt_id;
      word_d   = '0;
      to_d     = '0;
      cyc_d    = 1'b1;
      stb_d    = 1'b1;
      if (fill_mode[gnt_ch]) begin
        state_d = S_WR;
        we_d    = 1'b1;
        adr_d   = dst_addr(gnt_ch, '0);
        dat_d   = fill_data;
      end else begin
        state_d = S_RD;
        we_d    = 1'b0;
        adr_d   = src_addr(gnt_id, '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      rr_q      <= '0;
      fill_q    <= 1'b0;
      buf_id_q  <= '0;
      word_q    <= '0;
      to_q      <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      updated_q <= '0;
      error_q   <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      fill_q    <= fill_d;
      buf_id_q  <= buf_id_d;
      word_q    <= word_d;
      to_q      <= to_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      updated_q <= updated_d;
      error_q   <= error_d;
    end
  end

  assign wb.wbm_cycle     = cyc_q;
  assign wb.wbm_strobe    = stb_q;
  assign wb.wbm_write     = we_q;
  assign wb.wbm_address   = adr_q;
  assign wb.wbm_writedata = dat_q;
  assign buf_updated      = updated_q;
  assign buf_error        = error_q;
endmodule

// File: tb/tb_buf_updater_mc.sv
// Randomized bench for buf_updater_mc: pattern-backed Wishbone memory plus a transfer-level reference model.
module tb_buf_updater_mc;
  localparam int AW = 16, DW = 32, NCH = 4, BW = 64, TO = 255;
  localparam int SRC_B = 'h0000, DST_B = 'h8000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  buf_updater_mc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();
  logic [NCH*DW-1:0] buf_id;
  logic [NCH-1:0]    update_buf, fill_mode, buf_updated, buf_error;
  logic [DW-1:0]     fill_data;

  buf_updater_mc #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .BUF_WORDS(BW),
    .SRC_BASE(16'h0000), .DST_BASE(16'h8000), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .wb(wb), .buf_id(buf_id), .update_buf(update_buf),
    .fill_mode(fill_mode), .fill_data(fill_data), .buf_updated(buf_updated), .buf_error(buf_error)
  );

  // Memory: unwritten words read back as a seeded pattern, so source contents need no preload.
  logic [31:0]    mem [0:65535];
  logic [65535:0] written;
  logic [31:0]    pat_seed = 32'h1234_5678;
  logic           mem_clr = 1'b0;
  logic           ack_en = 1'b1;
  int rd_cnt = 0, wr_cnt = 0, seq_n = 0, proto_bad = 0;
  int seq [0:63];
  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] pat(input logic [31:0] s, input int a);
    return (s ^ (a * 32'h9E37_79B1)) + a;
  endfunction

  function automatic logic [31:0] mem_rd(input int a);
    return written[a] ? mem[a] : pat(pat_seed, a);
  endfunction

  function automatic int src_of(input logic [31:0] id, input int w);
    return int'((longint'(id) * BW + SRC_B + w) & 'hFFFF);
  endfunction

  function automatic int dst_of(input int c, input int w);
    return (DST_B + c * BW + w) & 'hFFFF;
  endfunction

  assign wb.wbm_ack      = wb.wbm_cycle & wb.wbm_strobe & ack_en;
  assign wb.wbm_readdata = mem_rd(int'(wb.wbm_address));

  always @(posedge clk) begin
    if (mem_clr) written <= '0;
    else if (wb.wbm_ack && wb.wbm_write) begin
      written[wb.wbm_address] <= 1'b1;
      mem[wb.wbm_address]     <= wb.wbm_writedata;
    end
    if (wb.wbm_ack) begin
      if (wb.wbm_write) wr_cnt <= wr_cnt + 1;
      else              rd_cnt <= rd_cnt + 1;
    end
    if (wb.wbm_ack && wb.wbm_write && wb.wbm_address >= 16'h8000 &&
        wb.wbm_address[5:0] == 6'd0 && seq_n < 64) begin
      seq[seq_n] <= int'((wb.wbm_address - 16'h8000) >> 6);
      seq_n      <= seq_n + 1;
    end
    if (wb.wbm_cycle !== wb.wbm_strobe) proto_bad <= proto_bad + 1;
  end

  task automatic new_test();
    reset = 1'b0; update_buf = '0; fill_mode = '0; buf_id = '0; fill_data = '0; ack_en = 1'b1;
    pat_seed = $urandom;
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Waits for buf_updated[c]; cnt = negedges waited (grant edge + N cycles gives N+1).
  task automatic wait_done(input int c, input int budget, output int cnt);
    cnt = 0;
    while (!buf_updated[c] && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; update_buf = '0; fill_mode = '0; buf_id = '0; fill_data = '0;
    @(negedge clk);
    n_cmp++;
    if ({wb.wbm_cycle, wb.wbm_strobe, wb.wbm_write} !== 3'b000) begin
      n_bad++; $display("FAIL reset_bus: cyc/stb/we=%b expected 000", {wb.wbm_cycle, wb.wbm_strobe, wb.wbm_write});
    end
    n_cmp++;
    if (wb.wbm_address !== '0 || wb.wbm_writedata !== '0) begin
      n_bad++; $display("FAIL reset_addr_data: addr=%h data=%h expected 0", wb.wbm_address, wb.wbm_writedata);
    end
    n_cmp++;
    if (buf_updated !== '0 || buf_error !== '0) begin
      n_bad++; $display("FAIL reset_flags: upd=%b err=%b expected 0", buf_updated, buf_error);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wb.wbm_cycle !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_request: cyc=%b expected 0", wb.wbm_cycle);
    end
  endtask

  task automatic test_copy();
    int cnt, rd0, wr0, bad;
    new_test();
    rd0 = rd_cnt; wr0 = wr_cnt;
    buf_id[0 +: DW] = 32'd2; update_buf[0] = 1'b1;
    wait_done(0, 400, cnt);
    $display("copy ch0 id=2 done after %0d cycles", cnt - 1);
    n_cmp++;
    if (cnt !== 257) begin n_bad++; $display("FAIL copy_latency: %0d cycles expected 256", cnt - 1); end
    n_cmp++;
    if (buf_error[0] !== 1'b0) begin n_bad++; $display("FAIL copy_error: %b expected 0", buf_error[0]); end
    n_cmp++;
    if (rd_cnt - rd0 !== 64 || wr_cnt - wr0 !== 64) begin
      n_bad++; $display("FAIL copy_counts: reads=%0d writes=%0d expected 64/64", rd_cnt - rd0, wr_cnt - wr0);
    end
    bad = 0;
    for (int w = 0; w < BW; w++) if (mem_rd(dst_of(0, w)) !== pat(pat_seed, src_of(32'd2, w))) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL copy_data: %0d bad words expected 0", bad); end
    n_cmp++;
    if (written[dst_of(1, 0)] !== 1'b0) begin n_bad++; $display("FAIL copy_overrun: 0x8040 written=1 expected 0"); end
    update_buf[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (buf_updated[0] !== 1'b0) begin n_bad++; $display("FAIL copy_release: upd=%b expected 0", buf_updated[0]); end
  endtask

  task automatic test_copy_random();
    int cnt, bad, c;
    logic [31:0] id;
    for (int k = 0; k < 3; k++) begin
      c  = $urandom_range(0, NCH - 1);
      id = (k == 2) ? 32'h0001_0401 : 32'($urandom_range(0, 511));
      buf_id[c*DW +: DW] = id; fill_mode[c] = 1'b0; update_buf[c] = 1'b1;
      wait_done(c, 400, cnt);
      buf_id[c*DW +: DW] = $urandom;
      bad = 0;
      for (int w = 0; w < BW; w++) if (mem_rd(dst_of(c, w)) !== pat(pat_seed, src_of(id, w))) bad++;
      $display("copy ch%0d id=%h done after %0d cycles", c, id, cnt - 1);
      n_cmp++;
      if (cnt >= 400 || bad != 0 || buf_error[c] !== 1'b0) begin
        n_bad++; $display("FAIL rand_copy_%0d: bad=%0d err=%b cnt=%0d expected 0/0/<400", k, bad, buf_error[c], cnt);
      end
      update_buf[c] = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_fill();
    int cnt, rd0, bad;
    new_test();
    rd0 = rd_cnt;
    fill_mode[1] = 1'b1; fill_data = 32'hDEAD_BEEF; update_buf[1] = 1'b1;
    @(negedge clk);
    fill_data = 32'h0BAD_F00D;
    wait_done(1, 300, cnt);
    cnt = cnt + 1;
    $display("fill ch1 data=DEADBEEF done after %0d cycles", cnt - 1);
    n_cmp++;
    if (cnt !== 129) begin n_bad++; $display("FAIL fill_latency: %0d cycles expected 128", cnt - 1); end
    n_cmp++;
    if (rd_cnt - rd0 !== 0) begin n_bad++; $display("FAIL fill_reads: %0d expected 0", rd_cnt - rd0); end
    bad = 0;
    for (int w = 0; w < BW; w++) if (mem_rd(dst_of(1, w)) !== 32'hDEAD_BEEF) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL fill_data: %0d bad words expected 0", bad); end
    update_buf[1] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cnt, seq0, bad;
    logic [31:0] ids [NCH];
    new_test();
    fill_mode[1] = 1'b1; fill_data = $urandom; update_buf[1] = 1'b1;
    wait_done(1, 300, cnt);
    update_buf[1] = 1'b0;
    repeat (2) @(negedge clk);
    seq0 = seq_n;
    fill_data = $urandom;
    for (int c = 0; c < NCH; c++) begin
      ids[c] = 32'($urandom_range(0, 511));
      buf_id[c*DW +: DW] = ids[c];
      fill_mode[c] = 1'($urandom_range(0, 1));
    end
    update_buf = '1;
    cnt = 0;
    while (buf_updated !== 4'hF && cnt < 1300) begin @(negedge clk); cnt++; end
    $display("round-robin modes=%b all done after %0d cycles", fill_mode, cnt);
    n_cmp++;
    if (buf_updated !== 4'hF) begin n_bad++; $display("FAIL rr_all_done: upd=%b expected 1111", buf_updated); end
    for (int k = 0; k < NCH; k++) begin
      n_cmp++;
      if (seq[seq0 + k] !== (2 + k) % NCH) begin
        n_bad++; $display("FAIL rr_order_%0d: ch%0d expected ch%0d", k, seq[seq0 + k], (2 + k) % NCH);
      end
    end
    bad = 0;
    for (int c = 0; c < NCH; c++)
      for (int w = 0; w < BW; w++)
        if (mem_rd(dst_of(c, w)) !== (fill_mode[c] ? fill_data : pat(pat_seed, src_of(ids[c], w)))) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL rr_data: %0d bad words expected 0", bad); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (buf_updated !== 4'hF || wb.wbm_cycle !== 1'b0) begin
      n_bad++; $display("FAIL rr_hold: upd=%b cyc=%b expected 1111/0", buf_updated, wb.wbm_cycle);
    end
    update_buf[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (buf_updated !== 4'b1011) begin n_bad++; $display("FAIL rr_release: upd=%b expected 1011", buf_updated); end
    update_buf = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (proto_bad !== 0) begin n_bad++; $display("FAIL cyc_eq_stb: %0d cycles differed expected 0", proto_bad); end
  endtask

  task automatic test_timeout();
    int hi, wr0, cnt, bad;
    new_test();
    wr0 = wr_cnt;
    ack_en = 1'b0;
    buf_id[0 +: DW] = 32'd5; update_buf[0] = 1'b1;
    @(negedge clk);
    hi = 0;
    while (wb.wbm_cycle && hi < 1000) begin hi++; @(negedge clk); end
    $display("timeout ch0: cycle held %0d cycles", hi);
    n_cmp++;
    if (hi !== TO) begin n_bad++; $display("FAIL timeout_len: %0d cycles expected %0d", hi, TO); end
    n_cmp++;
    if (buf_updated[0] !== 1'b1 || buf_error[0] !== 1'b1) begin
      n_bad++; $display("FAIL timeout_flags: upd=%b err=%b expected 1/1", buf_updated[0], buf_error[0]);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (wb.wbm_cycle !== 1'b0 || wr_cnt - wr0 !== 0) begin
      n_bad++; $display("FAIL timeout_no_retry: cyc=%b writes=%0d expected 0/0", wb.wbm_cycle, wr_cnt - wr0);
    end
    update_buf[0] = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (buf_error[0] !== 1'b0 || buf_updated[0] !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear: upd=%b err=%b expected 0/0", buf_updated[0], buf_error[0]);
    end
    buf_id[0 +: DW] = 32'd6; update_buf[0] = 1'b1;
    wait_done(0, 400, cnt);
    bad = 0;
    for (int w = 0; w < BW; w++) if (mem_rd(dst_of(0, w)) !== pat(pat_seed, src_of(32'd6, w))) bad++;
    $display("copy ch0 id=6 after timeout done after %0d cycles", cnt - 1);
    n_cmp++;
    if (cnt !== 257 || bad != 0 || buf_error[0] !== 1'b0) begin
      n_bad++; $display("FAIL after_timeout: cycles=%0d bad=%0d err=%b expected 256/0/0", cnt - 1, bad, buf_error[0]);
    end
    update_buf[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rd0, wr0, cnt, bad;
    logic [31:0] id;
    new_test();
    id = 32'($urandom_range(0, 511));
    rd0 = rd_cnt;
    buf_id[2*DW +: DW] = id; update_buf[2] = 1'b1;
    cnt = 0;
    while (rd_cnt - rd0 < 11 && cnt < 200) begin @(negedge clk); cnt++; end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({wb.wbm_cycle, wb.wbm_strobe, wb.wbm_write, wb.wbm_address, wb.wbm_writedata, buf_updated, buf_error} !== '0 ||
        rd_cnt - rd0 !== 11) begin
      n_bad++; $display("FAIL async_reset: cyc=%b stb=%b addr=%h reads=%0d expected 0/0/0000/11",
                        wb.wbm_cycle, wb.wbm_strobe, wb.wbm_address, rd_cnt - rd0);
    end
    @(negedge clk);
    reset = 1'b1;
    wr0 = wr_cnt;
    cnt = 0;
    while (!wb.wbm_strobe && cnt < 10) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (wb.wbm_strobe !== 1'b1 || wb.wbm_write !== 1'b0 || int'(wb.wbm_address) !== src_of(id, 0)) begin
      n_bad++; $display("FAIL restart_word0: stb=%b we=%b addr=%h expected 1/0/%h",
                        wb.wbm_strobe, wb.wbm_write, wb.wbm_address, src_of(id, 0));
    end
    wait_done(2, 400, cnt);
    bad = 0;
    for (int w = 0; w < BW; w++) if (mem_rd(dst_of(2, w)) !== pat(pat_seed, src_of(id, w))) bad++;
    $display("copy ch2 id=%h restarted after reset, done", id);
    n_cmp++;
    if (bad != 0 || wr_cnt - wr0 !== 64) begin
      n_bad++; $display("FAIL restart_data: bad=%0d writes=%0d expected 0/64", bad, wr_cnt - wr0);
    end
    update_buf[2] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdraw();
    int wr0, cnt, pulses, bad;
    logic err_seen;
    logic [31:0] id;
    new_test();
    id = 32'($urandom_range(0, 511));
    wr0 = wr_cnt;
    buf_id[3*DW +: DW] = id; update_buf[3] = 1'b1;
    cnt = 0;
    while (wr_cnt - wr0 < 5 && cnt < 100) begin @(negedge clk); cnt++; end
    update_buf[3] = 1'b0;
    pulses = 0; err_seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (buf_updated[3]) begin pulses++; err_seen = err_seen | buf_error[3]; end
    end
    bad = 0;
    for (int w = 0; w < BW; w++) if (mem_rd(dst_of(3, w)) !== pat(pat_seed, src_of(id, w))) bad++;
    $display("copy ch3 id=%h withdrawn mid-copy, %0d pulse(s)", id, pulses);
    n_cmp++;
    if (pulses !== 1 || err_seen !== 1'b0) begin
      n_bad++; $display("FAIL withdraw_pulse: pulses=%0d err=%b expected 1/0", pulses, err_seen);
    end
    n_cmp++;
    if (bad != 0 || wr_cnt - wr0 !== 64) begin
      n_bad++; $display("FAIL withdraw_data: bad=%0d writes=%0d expected 0/64", bad, wr_cnt - wr0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_copy();
    test_copy_random();
    test_fill();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
